// File: rtl/freq_sel_ctrl_pkg.sv
// Shared DPWM definitions: frequency index width/range and the
// frequency-select controller state encoding.
package freq_sel_ctrl_pkg;

    localparam int IDX_W = 3;

    typedef logic [IDX_W-1:0] idx_t;

    localparam idx_t IDX_MAX = 3'd7;
    localparam idx_t IDX_MIN = 3'd0;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_EDGE = 1'b1
    } fsel_state_e;

    // Saturating step of the requested index; simultaneous up/down cancel.
    function automatic idx_t idx_step(idx_t cur, logic up, logic dn);
        idx_t nxt;
        nxt = cur;
        if (up && !dn && cur != IDX_MAX) begin
            nxt = cur + idx_t'(1);
        end else if (dn && !up && cur != IDX_MIN) begin
            nxt = cur - idx_t'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/freq_sel_ctrl_if.sv
// Signal bundle between the button/DPWM side and the frequency-select controller.
// The controller is the slave: it consumes buttons and DPWM status, drives the index.
interface freq_sel_ctrl_if;

    logic                               btn_up;
    logic                               btn_down;
    logic                               dpwm_en;
    logic                               period_end;
    freq_sel_ctrl_pkg::idx_t            outcont3;
    logic                               freq_load;
    logic                               pending;
    freq_sel_ctrl_pkg::fsel_state_e     state_dbg;

    modport slave (
        input  btn_up,
        input  btn_down,
        input  dpwm_en,
        input  period_end,
        output outcont3,
        output freq_load,
        output pending,
        output state_dbg
    );

    modport master (
        output btn_up,
        output btn_down,
        output dpwm_en,
        output period_end,
        input  outcont3,
        input  freq_load,
        input  pending,
        input  state_dbg
    );

endinterface

// File: rtl/freq_sel_ctrl_btn_debounce.sv
// Button front end: 2-flop synchronizer, stability-count debouncer and
// rising-edge detector producing a one-cycle press strobe.
module btn_debounce #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    localparam logic [15:0] CNT_LAST = 16'(DEB_CYCLES - 1);

    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        deb_q,   deb_d;
    logic [15:0] cnt_q,   cnt_d;
    logic        press_q, press_d;

    // The counter only runs while the synchronized level disagrees with the
    // accepted level, so any bounce back to the accepted level restarts it.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = cnt_q;
        if (sync2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            deb_d = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
        press_d = deb_d & ~deb_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/freq_sel_ctrl.sv
// Frequency-select controller: debounced up/down buttons adjust a requested
// index that is applied to outcont3 only at a PWM period boundary.
module freq_sel_ctrl
    import freq_sel_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = 50000,
    parameter int INIT_IDX   = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    freq_sel_ctrl_if.slave  bus
);

    localparam idx_t INIT_V = idx_t'(INIT_IDX);

    logic        up_press;
    logic        dn_press;

    fsel_state_e state_q, state_d;
    idx_t        req_q,   req_d;
    idx_t        out_q,   out_d;
    logic        load_q,  load_d;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (bus.btn_up),
        .press   (up_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (bus.btn_down),
        .press   (dn_press)
    );

    // The applied value is req_d, so a press landing in the boundary cycle
    // is already folded in when outcont3 is updated.
    always_comb begin
        req_d   = idx_step(req_q, up_press, dn_press);
        state_d = state_q;
        out_d   = out_q;
        load_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_q != out_q) begin
                    state_d = WAIT_EDGE;
                end
            end
            WAIT_EDGE: begin
                if (!bus.dpwm_en || bus.period_end) begin
                    state_d = IDLE;
                    if (req_d != out_q) begin
                        out_d  = req_d;
                        load_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= INIT_V;
            out_q   <= INIT_V;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            out_q   <= out_d;
            load_q  <= load_d;
        end
    end

    assign bus.outcont3  = out_q;
    assign bus.freq_load = load_q;
    assign bus.pending   = (state_q == WAIT_EDGE);
    assign bus.state_dbg = state_q;

endmodule
